// File: rtl/ex_forward_ctrl.sv
// rtl/ex_forward_ctrl.sv - EX-stage operand forward select and load-use stall control
module ex_forward_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_uses_rt_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_regwrite_i,
    input  logic              id_memread_i,
    input  logic              flush_i,
    output logic [1:0]        forward_a_o,
    output logic [1:0]        forward_b_o,
    output logic              stall_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam logic [REG_AW-1:0] REG_ZERO = '0;
    localparam logic [1:0]        FWD_ID   = 2'b00;
    localparam logic [1:0]        FWD_WB   = 2'b01;
    localparam logic [1:0]        FWD_MEM  = 2'b10;
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    // Record of the instruction currently in EX (becomes EX/MEM after the edge)
    logic              ex_valid_q,    ex_valid_d;
    logic [REG_AW-1:0] ex_rd_q,       ex_rd_d;
    logic              ex_regwrite_q, ex_regwrite_d;
    logic              ex_memread_q,  ex_memread_d;

    // Record of the instruction currently in MEM (becomes MEM/WB after the edge)
    logic              mem_valid_q,    mem_valid_d;
    logic [REG_AW-1:0] mem_rd_q,       mem_rd_d;
    logic              mem_regwrite_q, mem_regwrite_d;

    logic [1:0]        forward_a_q, forward_a_d;
    logic [1:0]        forward_b_q, forward_b_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic              ex_writes_rs;
    logic              ex_writes_rt;
    logic              mem_writes_rs;
    logic              mem_writes_rt;
    logic              ex_load_hit;
    logic              stall;
    logic              insert;

    // Producer match terms; register 0 is hard-wired and never a producer
    always_comb begin
        ex_writes_rs  = ex_valid_q && ex_regwrite_q && (ex_rd_q != REG_ZERO)
                        && (ex_rd_q == id_rs_i);
        ex_writes_rt  = ex_valid_q && ex_regwrite_q && (ex_rd_q != REG_ZERO)
                        && (ex_rd_q == id_rt_i);
        mem_writes_rs = mem_valid_q && mem_regwrite_q && (mem_rd_q != REG_ZERO)
                        && (mem_rd_q == id_rs_i);
        mem_writes_rt = mem_valid_q && mem_regwrite_q && (mem_rd_q != REG_ZERO)
                        && (mem_rd_q == id_rt_i);
    end

    // Load-use detection; a flush kills the consumer so there is nothing to stall
    always_comb begin
        ex_load_hit = ex_valid_q && ex_memread_q && (ex_rd_q != REG_ZERO)
                      && ((ex_rd_q == id_rs_i) || (id_uses_rt_i && (ex_rd_q == id_rt_i)));
        stall       = !flush_i && id_valid_i && ex_load_hit;
        insert      = id_valid_i && !flush_i && !stall;
    end

    // Next pipeline records: MEM always advances, EX takes the ID instruction or a bubble
    always_comb begin
        mem_valid_d    = ex_valid_q;
        mem_rd_d       = ex_rd_q;
        mem_regwrite_d = ex_regwrite_q;

        ex_valid_d     = 1'b0;
        ex_rd_d        = id_rd_i;
        ex_regwrite_d  = 1'b0;
        ex_memread_d   = 1'b0;
        if (insert) begin
            ex_valid_d    = 1'b1;
            ex_regwrite_d = id_regwrite_i;
            ex_memread_d  = id_memread_i;
        end
    end

    // Forward selects for the entering instruction; the newest producer (EX) wins
    always_comb begin
        forward_a_d = FWD_ID;
        forward_b_d = FWD_ID;
        if (insert) begin
            if (ex_writes_rs) begin
                forward_a_d = FWD_MEM;
            end else if (mem_writes_rs) begin
                forward_a_d = FWD_WB;
            end

            if (id_uses_rt_i && ex_writes_rt) begin
                forward_b_d = FWD_MEM;
            end else if (id_uses_rt_i && mem_writes_rt) begin
                forward_b_d = FWD_WB;
            end
        end
    end

    // Saturating stall counter for performance debug
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
    end

    // State registers; reset empties the pipeline records and clears the selects
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_valid_q     <= 1'b0;
            ex_rd_q        <= REG_ZERO;
            ex_regwrite_q  <= 1'b0;
            ex_memread_q   <= 1'b0;
            mem_valid_q    <= 1'b0;
            mem_rd_q       <= REG_ZERO;
            mem_regwrite_q <= 1'b0;
            forward_a_q    <= FWD_ID;
            forward_b_q    <= FWD_ID;
            stall_cnt_q    <= '0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_rd_q        <= ex_rd_d;
            ex_regwrite_q  <= ex_regwrite_d;
            ex_memread_q   <= ex_memread_d;
            mem_valid_q    <= mem_valid_d;
            mem_rd_q       <= mem_rd_d;
            mem_regwrite_q <= mem_regwrite_d;
            forward_a_q    <= forward_a_d;
            forward_b_q    <= forward_b_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

    assign forward_a_o = forward_a_q;
    assign forward_b_o = forward_b_q;
    assign stall_o     = stall;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_ex_forward_ctrl.sv
// tb/tb_ex_forward_ctrl.sv - directed self-checking bench for ex_forward_ctrl
module tb_ex_forward_ctrl;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 5;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              id_valid_i;
    logic [REG_AW-1:0] id_rs_i;
    logic [REG_AW-1:0] id_rt_i;
    logic              id_uses_rt_i;
    logic [REG_AW-1:0] id_rd_i;
    logic              id_regwrite_i;
    logic              id_memread_i;
    logic              flush_i;
    logic [1:0]        forward_a_o;
    logic [1:0]        forward_b_o;
    logic              stall_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    int errors = 0;
    int checks = 0;
    logic [CNT_W-1:0] exp_cnt = '0;

    ex_forward_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .id_valid_i    (id_valid_i),
        .id_rs_i       (id_rs_i),
        .id_rt_i       (id_rt_i),
        .id_uses_rt_i  (id_uses_rt_i),
        .id_rd_i       (id_rd_i),
        .id_regwrite_i (id_regwrite_i),
        .id_memread_i  (id_memread_i),
        .flush_i       (flush_i),
        .forward_a_o   (forward_a_o),
        .forward_b_o   (forward_b_o),
        .stall_o       (stall_o),
        .stall_cnt_o   (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic ut, input logic [4:0] rd, input logic rw,
                         input logic mr, input logic fl);
        id_valid_i    = v;
        id_rs_i       = rs;
        id_rt_i       = rt;
        id_uses_rt_i  = ut;
        id_rd_i       = rd;
        id_regwrite_i = rw;
        id_memread_i  = mr;
        flush_i       = fl;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle2();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        drive(1'b1, 5'd6, 5'd6, 1'b1, 5'd6, 1'b1, 1'b1, 1'b0);
        #12;
        checks++;
        if (forward_a_o !== 2'b00) begin errors++; $display("FAIL reset_fwd_a got=%b exp=00", forward_a_o); end
        checks++;
        if (forward_b_o !== 2'b00) begin errors++; $display("FAIL reset_fwd_b got=%b exp=00", forward_b_o); end
        checks++;
        if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall_o); end
        checks++;
        if (stall_cnt_o !== '0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt_o); end
        rst_i = 1'b0;
        idle2();
    endtask

    task automatic test_adjacent_raw();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd3, 5'd2, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
        tick();
        checks++;
        if (forward_a_o !== 2'b10) begin errors++; $display("FAIL adj_fwd_a got=%b exp=10", forward_a_o); end
        checks++;
        if (forward_b_o !== 2'b00) begin errors++; $display("FAIL adj_fwd_b got=%b exp=00", forward_b_o); end
        idle2();
    endtask

    task automatic test_distance2();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd1, 5'd4, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        tick();
        checks++;
        if (forward_b_o !== 2'b01) begin errors++; $display("FAIL dist2_fwd_b got=%b exp=01", forward_b_o); end
        checks++;
        if (forward_a_o !== 2'b00) begin errors++; $display("FAIL dist2_fwd_a got=%b exp=00", forward_a_o); end
        idle2();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd1, 5'd4, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
        tick();
        checks++;
        if (forward_b_o !== 2'b00) begin errors++; $display("FAIL dist2_no_rt got=%b exp=00", forward_b_o); end
        idle2();
    endtask

    task automatic test_double_hit();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        drive(1'b1, 5'd5, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        tick();
        checks++;
        if (forward_a_o !== 2'b10) begin errors++; $display("FAIL double_fwd_a got=%b exp=10", forward_a_o); end
        drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        tick();
        checks++;
        if (forward_a_o !== 2'b00) begin errors++; $display("FAIL r0_fwd_a got=%b exp=00", forward_a_o); end
        checks++;
        if (forward_b_o !== 2'b00) begin errors++; $display("FAIL r0_fwd_b got=%b exp=00", forward_b_o); end
        drive(1'b1, 5'd1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (stall_o !== 1'b0) begin errors++; $display("FAIL r0_load_stall got=%b exp=0", stall_o); end
        tick();
        idle2();
    endtask

    task automatic test_load_use();
        drive(1'b1, 5'd1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd6, 5'd2, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (stall_o !== 1'b1) begin errors++; $display("FAIL lu_stall got=%b exp=1", stall_o); end
        tick();
        exp_cnt = exp_cnt + 1'b1;
        checks++;
        if (forward_a_o !== 2'b00 || forward_b_o !== 2'b00) begin
            errors++; $display("FAIL lu_bubble_sel got=%b/%b exp=00/00", forward_a_o, forward_b_o);
        end
        checks++;
        if (stall_cnt_o !== exp_cnt) begin errors++; $display("FAIL lu_cnt got=%0d exp=%0d", stall_cnt_o, exp_cnt); end
        #1;
        checks++;
        if (stall_o !== 1'b0) begin errors++; $display("FAIL lu_second_stall got=%b exp=0", stall_o); end
        tick();
        checks++;
        if (forward_a_o !== 2'b01) begin errors++; $display("FAIL lu_fwd_a got=%b exp=01", forward_a_o); end
        checks++;
        if (stall_cnt_o !== exp_cnt) begin errors++; $display("FAIL lu_cnt_hold got=%0d exp=%0d", stall_cnt_o, exp_cnt); end
        idle2();
        drive(1'b1, 5'd1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd1, 5'd11, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (stall_o !== 1'b0) begin errors++; $display("FAIL lu_rt_unused got=%b exp=0", stall_o); end
        id_uses_rt_i = 1'b1;
        #1;
        checks++;
        if (stall_o !== 1'b1) begin errors++; $display("FAIL lu_rt_used got=%b exp=1", stall_o); end
        id_uses_rt_i = 1'b0;
        tick();
        checks++;
        if (forward_b_o !== 2'b00) begin errors++; $display("FAIL lu_rt_fwd_b got=%b exp=00", forward_b_o); end
        idle2();
    endtask

    task automatic test_flush();
        drive(1'b1, 5'd1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd7, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
        #1;
        checks++;
        if (stall_o !== 1'b0) begin errors++; $display("FAIL flush_stall got=%b exp=0", stall_o); end
        tick();
        checks++;
        if (stall_cnt_o !== exp_cnt) begin errors++; $display("FAIL flush_cnt got=%0d exp=%0d", stall_cnt_o, exp_cnt); end
        checks++;
        if (forward_a_o !== 2'b00) begin errors++; $display("FAIL flush_fwd_a got=%b exp=00", forward_a_o); end
        drive(1'b1, 5'd7, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (stall_o !== 1'b0) begin errors++; $display("FAIL flush_after_stall got=%b exp=0", stall_o); end
        tick();
        checks++;
        if (forward_a_o !== 2'b01) begin errors++; $display("FAIL flush_after_fwd_a got=%b exp=01", forward_a_o); end
        idle2();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 5'd1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b1, 1'b0);
            tick();
            drive(1'b1, 5'd12, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0, 1'b0);
            tick();
            if (exp_cnt != CNT_MAX) exp_cnt = exp_cnt + 1'b1;
            checks++;
            if (stall_cnt_o !== exp_cnt) begin
                errors++; $display("FAIL sat_cnt iter=%0d got=%0d exp=%0d", i, stall_cnt_o, exp_cnt);
            end
            tick();
        end
        checks++;
        if (stall_cnt_o !== CNT_MAX) begin errors++; $display("FAIL sat_final got=%0d exp=%0d", stall_cnt_o, CNT_MAX); end
        idle2();
    endtask

    task automatic test_async_reset();
        drive(1'b1, 5'd1, 5'd0, 1'b0, 5'd15, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd15, 5'd0, 1'b0, 5'd14, 1'b1, 1'b1, 1'b0);
        tick();
        checks++;
        if (forward_a_o !== 2'b10) begin errors++; $display("FAIL prerst_fwd_a got=%b exp=10", forward_a_o); end
        drive(1'b1, 5'd14, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (stall_o !== 1'b1) begin errors++; $display("FAIL prerst_stall got=%b exp=1", stall_o); end
        rst_i = 1'b1;
        #1;
        exp_cnt = '0;
        checks++;
        if (forward_a_o !== 2'b00) begin errors++; $display("FAIL arst_fwd_a got=%b exp=00", forward_a_o); end
        checks++;
        if (stall_o !== 1'b0) begin errors++; $display("FAIL arst_stall got=%b exp=0", stall_o); end
        checks++;
        if (stall_cnt_o !== exp_cnt) begin errors++; $display("FAIL arst_cnt got=%0d exp=0", stall_cnt_o); end
        rst_i = 1'b0;
        #1;
        tick();
        checks++;
        if (forward_a_o !== 2'b00) begin errors++; $display("FAIL postrst_fwd_a got=%b exp=00", forward_a_o); end
        checks++;
        if (stall_cnt_o !== exp_cnt) begin errors++; $display("FAIL postrst_cnt got=%0d exp=0", stall_cnt_o); end
        idle2();
    endtask

    initial begin
        test_reset();
        test_adjacent_raw();
        test_distance2();
        test_double_hit();
        test_load_use();
        test_flush();
        test_saturation();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_forward_ctrl.md
Name: ex_forward_ctrl

Overview:
- Control stage directly upstream of the two EX-stage 3:1 operand muxes (ALU source A and B) in the 5-stage pipelined CPU.
- Tracks destination-register info of the in-flight instructions in EX/MEM and MEM/WB, and produces registered 2-bit forward selects for the instruction entering EX.
- Detects load-use hazards and requests a one-cycle stall with bubble insertion.
- Keeps a saturating stall counter for performance debug.

Parameters:
- REG_AW, 5, register-address width.
- CNT_W, 16, stall counter width.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- id_valid_i  input  1  ID/EX candidate is a real instruction.
- id_rs_i  input  REG_AW  source A register of the ID instruction.
- id_rt_i  input  REG_AW  source B register of the ID instruction.
- id_uses_rt_i  input  1  rt is a read operand (0 for I-type whose rt is the destination).
- id_rd_i  input  REG_AW  destination register of the ID instruction.
- id_regwrite_i  input  1  ID instruction writes the register file.
- id_memread_i  input  1  ID instruction is a load.
- flush_i  input  1  branch-taken flush; the ID instruction must not enter EX.
- forward_a_o  output  2  select for the ALU-A mux: 00 = ID/EX register value, 01 = MEM/WB write-back data, 10 = EX/MEM ALU result.
- forward_b_o  output  2  same encoding for the ALU-B mux. 11 is never driven.
- stall_o  output  1  hold PC and IF/ID this cycle and insert a bubble into EX.
- stall_cnt_o  output  CNT_W  number of stall cycles, saturating.

Behaviour:
- Internal stage records: EX = {valid, rd, regwrite, memread}; MEM = {valid, rd, regwrite}.
- "Writes r" means valid && regwrite && rd != 0 && rd == r. Register 0 never forwards and never stalls.
- Reset (async, rst_i=1):
  - All valid bits = 0; forward_a_o = forward_b_o = 00; stall_cnt_o = 0.
  - stall_o = 0 (follows, since EX.valid = 0).
  - Reset deasserted mid-sequence: behaviour restarts as an empty pipeline; no forward to pre-reset instructions.
- stall_o (combinational):
  - stall_o = !flush_i && id_valid_i && EX.valid && EX.memread && EX.rd != 0 && (EX.rd == id_rs_i || (id_uses_rt_i && EX.rd == id_rt_i)).
- Each rising edge, all updates simultaneous:
  - MEM <= EX (valid, rd, regwrite).
  - insert = id_valid_i && !flush_i && !stall_o.
  - If insert: EX <= ID fields with valid = 1. Otherwise EX <= bubble: valid = 0, regwrite = 0, memread = 0.
  - forward_a_o <= computed against the pre-edge EX and MEM records (they become EX/MEM and MEM/WB after the edge):
    - 10 if insert && pre-edge EX writes id_rs_i;
    - else 01 if insert && pre-edge MEM writes id_rs_i;
    - else 00.
  - forward_b_o <= same rule with id_rt_i, gated by id_uses_rt_i.
  - Bubbles always get 00/00.
- Priority: when both the EX/MEM and MEM/WB records match, select 10 (the newest producer wins).
- Load-use resolution:
  - Cycle of the stall: bubble enters EX.
  - Next cycle: the load sits in MEM and its data comes from MEM/WB, so the dependent instruction gets 01. No second stall.
- flush_i priority:
  - flush_i overrides stall_o (stall_o forced 0) and forces a bubble into EX.
  - EX and MEM records still advance normally.
- stall_cnt_o increments by 1 on every edge with stall_o = 1. It holds at all-ones (saturates, no wrap).
- Latency: forward selects are valid from the first cycle the instruction is in EX, driven straight from flops.

Test Plan:
- Adjacent RAW: add r3 (regwrite) followed by sub rs=r3 -> forward_a_o = 10 while sub is in EX; forward_b_o = 00.
- Distance 2: add r4, nop, then and rt=r4 with id_uses_rt_i = 1 -> forward_b_o = 01. The same pattern with id_uses_rt_i = 0 -> forward_b_o = 00.
- Double hit: add r5, add r5, then or rs=r5 -> forward_a_o = 10, not 01. A producer with rd = r0 followed by a consumer of r0 -> 00.
- Load-use: lw r6, then add rs=r6:
  - stall_o = 1 for exactly one cycle and EX holds a bubble (selects 00);
  - next cycle the add is in EX with forward_a_o = 01;
  - stall_cnt_o = 1.
- Flush during hazard: lw r7, then beq rs=r7 with flush_i = 1 -> stall_o = 0, bubble inserted, stall_cnt_o unchanged.
- Saturation / reset:
  - preload the counter near max with repeated load-use pairs -> stall_cnt_o holds at 0xFFFF;
  - assert rst_i asynchronously between edges -> outputs clear immediately, and the next dependent instruction gets 00.
